usb_tx_sched: RTL and testbench

Transmit packet scheduler sitting directly in front of the UTM transmit path. It shares the single UTMI tx byte port between two requesters: the handshake source (one-byte ACK/NAK/STALL packets) and the data source (DATAx packets with payload and appended CRC16). It builds the PID byte, streams the payload and CRC16 under the tx_valid/tx_ready handshake, and enforces an inter-packet gap so the transmitter can finish EOP before the next packet starts.

---
 rtl/usb_tx_sched.sv | 185 ++++++++++++++++++
 tb/tb_usb_tx_sched.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_sched.sv
// usb_tx_sched: arbitrates the UTMI tx byte port between a handshake source
// (single PID byte) and a data source (PID, payload, CRC16), then holds an
// inter-packet gap so the transmitter can finish EOP.
// Ports: hs_req/hs_pid/hs_ack (handshake source), dat_req/dat_pid/dat_len/
// dat_byte/dat_rd/dat_ack (data source, FWFT payload), tx_data/tx_valid/
// tx_ready (UTMI tx), busy (not IDLE). PID appears one cycle after grant;
// tx_valid/tx_data hold while tx_ready is low.
module usb_tx_sched #(
  parameter int MAX_LEN    = 64,
  parameter int LEN_W      = $clog2(MAX_LEN + 1),
  parameter int GAP_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hs_req,
  input  logic [3:0]       hs_pid,
  output logic             hs_ack,
  input  logic             dat_req,
  input  logic [3:0]       dat_pid,
  input  logic [LEN_W-1:0] dat_len,
  input  logic [7:0]       dat_byte,
  output logic             dat_rd,
  output logic             dat_ack,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PID    = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CRC_LO = 3'd3;
  localparam logic [2:0] S_CRC_HI = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;

  logic [2:0]       state_q, state_d;
  logic             is_hs_q, is_hs_d;
  logic [3:0]       pid_q, pid_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [15:0]      crc_q, crc_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             hs_ack_q, hs_ack_d;
  logic             dat_ack_q, dat_ack_d;
  logic             accept;
  logic [LEN_W-1:0] cnt_inc;

  // CRC16 (poly 0x8005), one byte fed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = b[i] ^ c[15];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h8005;
    end
    return c;
  endfunction

  // Output decode: purely a function of state so reset clears it at once.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dat_rd   = 1'b0;
    case (state_q)
      S_PID: begin
        tx_valid = 1'b1;
        tx_data  = {~pid_q, pid_q};
      end
      S_DATA: begin
        tx_valid = 1'b1;
        tx_data  = dat_byte;
        dat_rd   = tx_ready;
      end
      S_CRC_LO: begin
        tx_valid = 1'b1;
        tx_data  = ~crc_q[7:0];
      end
      S_CRC_HI: begin
        tx_valid = 1'b1;
        tx_data  = ~crc_q[15:8];
      end
      default: ;
    endcase
  end

  assign accept  = tx_valid && tx_ready;
  assign busy    = (state_q != S_IDLE);
  assign hs_ack  = hs_ack_q;
  assign dat_ack = dat_ack_q;
  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d   = state_q;
    is_hs_d   = is_hs_q;
    pid_d     = pid_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    gap_d     = gap_q;
    hs_ack_d  = 1'b0;
    dat_ack_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hs_req) begin
          is_hs_d = 1'b1;
          pid_d   = hs_pid;
          state_d = S_PID;
        end else if (dat_req) begin
          is_hs_d = 1'b0;
          pid_d   = dat_pid;
          len_d   = (dat_len > MAX_LEN_L) ? MAX_LEN_L : dat_len;
          cnt_d   = '0;
          crc_d   = 16'hFFFF;
          state_d = S_PID;
        end
      end
      S_PID: begin
        if (accept) begin
          if (is_hs_q) begin
            hs_ack_d = 1'b1;
            gap_d    = GAP_W'(GAP_CYCLES - 1);
            state_d  = S_GAP;
          end else if (len_q == '0) begin
            state_d = S_CRC_LO;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          crc_d = crc16_byte(crc_q, dat_byte);
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = S_CRC_LO;
        end
      end
      S_CRC_LO: begin
        if (accept) state_d = S_CRC_HI;
      end
      S_CRC_HI: begin
        if (accept) begin
          dat_ack_d = 1'b1;
          gap_d     = GAP_W'(GAP_CYCLES - 1);
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      is_hs_q   <= 1'b0;
      pid_q     <= 4'h0;
      len_q     <= '0;
      cnt_q     <= '0;
      crc_q     <= 16'h0000;
      gap_q     <= '0;
      hs_ack_q  <= 1'b0;
      dat_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_hs_q   <= is_hs_d;
      pid_q     <= pid_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      gap_q     <= gap_d;
      hs_ack_q  <= hs_ack_d;
      dat_ack_q <= dat_ack_d;
    end
  end

endmodule

// File: tb/tb_usb_tx_sched.sv
module tb_usb_tx_sched;
  localparam int MAX_LEN = 64;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int GAP     = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             hs_req = 1'b0;
  logic [3:0]       hs_pid = 4'h0;
  logic             hs_ack;
  logic             dat_req = 1'b0;
  logic [3:0]       dat_pid = 4'h0;
  logic [LEN_W-1:0] dat_len = '0;
  logic [7:0]       dat_byte;
  logic             dat_rd;
  logic             dat_ack;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready = 1'b1;
  logic             busy;

  usb_tx_sched #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .hs_req(hs_req), .hs_pid(hs_pid), .hs_ack(hs_ack),
    .dat_req(dat_req), .dat_pid(dat_pid), .dat_len(dat_len),
    .dat_byte(dat_byte), .dat_rd(dat_rd), .dat_ack(dat_ack),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Payload source: FWFT, advances on each dat_rd.
  logic [7:0] payload [256];
  logic [7:0] idx = 8'd0;
  logic       src_clr = 1'b0;
  assign dat_byte = payload[idx];
  always @(posedge clk) begin
    if (src_clr)     idx <= 8'd0;
    else if (dat_rd) idx <= idx + 8'd1;
  end

  int cyc = 0;
  int ready_mode = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    tx_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4) == 0);
  end

  // Scoreboard entry: {kind, byte}; kind 1 = last byte of handshake, 2 = last of data.
  logic [9:0] exp_q [$];
  logic       sb_en = 1'b1;
  int         pend = 0;
  int         last_acc_cyc = -1;
  int         sep_last = -1;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic       prev_valid = 1'b0;
  int         dat_rd_cnt = 0, hs_ack_cnt = 0, dat_ack_cnt = 0;

  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst_n) begin
      stall_prev = 1'b0;
      prev_valid = 1'b0;
      pend = 0;
    end else begin
      if (dat_rd)  dat_rd_cnt++;
      if (hs_ack)  begin hs_ack_cnt++;  hs_req = 1'b0;  end
      if (dat_ack) begin dat_ack_cnt++; dat_req = 1'b0; end
      if (sb_en) begin
        if (pend != 0) begin
          checks++;
          if (tx_valid !== 1'b0 || hs_ack !== (pend == 1) || dat_ack !== (pend == 2)) begin
            errors++;
            $display("FAIL end_of_packet: valid=%b hs_ack=%b dat_ack=%b, required valid=0 ack kind=%0d",
                     tx_valid, hs_ack, dat_ack, pend);
          end
          pend = 0;
        end
        if (stall_prev && tx_valid) begin
          checks++;
          if (tx_data !== stall_data) begin
            errors++;
            $display("FAIL hold_while_stalled: data=%h required %h", tx_data, stall_data);
          end
        end
        if (tx_valid && !prev_valid && last_acc_cyc >= 0) sep_last = cyc - last_acc_cyc;
        if (tx_valid && tx_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte: got %h, required no transfer", tx_data);
          end else begin
            e = exp_q.pop_front();
            if (tx_data !== e[7:0]) begin
              errors++;
              $display("FAIL tx_byte: got %h required %h", tx_data, e[7:0]);
            end
            if (e[9:8] != 2'd0) begin
              pend = int'(e[9:8]);
              last_acc_cyc = cyc;
            end
          end
        end
      end
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
      prev_valid = tx_valid;
    end
  end

  function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (b[i] ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  task automatic push_dat(input logic [3:0] pid, input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    exp_q.push_back({2'd0, ~pid, pid});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({2'd0, payload[i]});
      c = crc_upd(c, payload[i]);
    end
    exp_q.push_back({2'd0, ~c[7:0]});
    exp_q.push_back({2'd2, ~c[15:8]});
  endtask

  task automatic start_src();
    src_clr = 1'b1;
    @(posedge clk); #1;
    src_clr = 1'b0;
    dat_rd_cnt = 0; hs_ack_cnt = 0; dat_ack_cnt = 0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0 || pend != 0 || hs_req || dat_req) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_timeout: %0d bytes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
      hs_req = 1'b0; dat_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || dat_rd !== 1'b0 ||
        hs_ack !== 1'b0 || dat_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h busy=%b rd=%b hs_ack=%b dat_ack=%b, required all 0",
               tx_valid, tx_data, busy, dat_rd, hs_ack, dat_ack);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_handshake();
    start_src();
    ready_mode = 0;
    exp_q.push_back({2'd1, 8'hD2});
    hs_pid = 4'h2;
    hs_req = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL grant_latency_early: valid=%b required 0", tx_valid);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL grant_latency: valid=%b busy=%b required 1 1", tx_valid, busy);
    end
    wait_idle("handshake");
    checks++;
    if (hs_ack_cnt != 1 || dat_ack_cnt != 0) begin
      errors++;
      $display("FAIL handshake_acks: hs=%0d dat=%0d required 1 0", hs_ack_cnt, dat_ack_cnt);
    end
  endtask

  task automatic test_zero_len();
    start_src();
    exp_q.push_back({2'd0, 8'hC3});
    exp_q.push_back({2'd0, 8'h00});
    exp_q.push_back({2'd2, 8'h00});
    dat_pid = 4'h3; dat_len = '0; dat_req = 1'b1;
    wait_idle("zero_len");
    checks++;
    if (dat_rd_cnt != 0 || dat_ack_cnt != 1) begin
      errors++;
      $display("FAIL zero_len_counts: rd=%0d ack=%0d required 0 1", dat_rd_cnt, dat_ack_cnt);
    end
  endtask

  task automatic test_payload_stall();
    for (int i = 0; i < 4; i++) payload[i] = 8'(i);
    start_src();
    ready_mode = 1;
    push_dat(4'hB, 4);
    dat_pid = 4'hB; dat_len = LEN_W'(4); dat_req = 1'b1;
    wait_idle("payload_stall");
    ready_mode = 0;
    checks++;
    if (dat_rd_cnt != 4 || dat_ack_cnt != 1) begin
      errors++;
      $display("FAIL payload_counts: rd=%0d ack=%0d required 4 1", dat_rd_cnt, dat_ack_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) payload[i] = 8'(8'hA0 + i * 3);
    start_src();
    sep_last = -1;
    exp_q.push_back({2'd1, 8'h5A});
    push_dat(4'h4, 5);
    hs_pid = 4'hA; hs_req = 1'b1;
    dat_pid = 4'h4; dat_len = LEN_W'(5); dat_req = 1'b1;
    wait_idle("back_to_back");
    checks++;
    if (hs_ack_cnt != 1 || dat_ack_cnt != 1) begin
      errors++;
      $display("FAIL b2b_acks: hs=%0d dat=%0d required 1 1", hs_ack_cnt, dat_ack_cnt);
    end
    checks++;
    if (sep_last != GAP + 2) begin
      errors++;
      $display("FAIL b2b_gap: separation=%0d required %0d", sep_last, GAP + 2);
    end
  endtask

  task automatic test_max_len();
    for (int i = 0; i < 256; i++) payload[i] = 8'(i * 7 + 3);
    start_src();
    push_dat(4'hC, MAX_LEN);
    dat_pid = 4'hC; dat_len = LEN_W'(MAX_LEN + 5); dat_req = 1'b1;
    wait_idle("max_len");
    checks++;
    if (dat_rd_cnt != MAX_LEN) begin
      errors++;
      $display("FAIL max_len_reads: rd=%0d required %0d", dat_rd_cnt, MAX_LEN);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    for (int i = 0; i < 10; i++) payload[i] = 8'(i * 5 + 1);
    start_src();
    sb_en = 1'b0;
    dat_pid = 4'h3; dat_len = LEN_W'(10); dat_req = 1'b1;
    n = 0;
    while (dat_rd_cnt < 3 && n < 200) begin @(negedge clk); n++; end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || dat_rd !== 1'b0 || n >= 200) begin
      errors++;
      $display("FAIL reset_mid_packet: valid=%b busy=%b rd=%b wait=%0d, required 0 0 0 <200",
               tx_valid, busy, dat_rd, n);
    end
    exp_q.delete();
    start_src();
    push_dat(4'h3, 10);
    sb_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_idle("reset_restart");
    checks++;
    if (dat_rd_cnt != 10 || dat_ack_cnt != 1) begin
      errors++;
      $display("FAIL restart_counts: rd=%0d ack=%0d required 10 1", dat_rd_cnt, dat_ack_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) payload[i] = 8'h00;
    test_reset();
    test_handshake();
    test_zero_len();
    test_payload_stall();
    test_back_to_back();
    test_max_len();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
